// File: rtl/rom_loader_pkg.sv
// Shared types and defaults for the boot-time program loader.
// The state encoding is visible to checkers through the top-level debug port.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    HEADER = 3'd0,
    HI     = 3'd1,
    LO     = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_e;

  localparam int DEF_ADDR_WIDTH     = 8;
  localparam int DEF_DATA_WIDTH     = 12;
  localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

  // The upper nibble of a HI byte must be zero.
  localparam logic [7:0] HI_RSVD_MASK = 8'hF0;

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input and program-RAM write port of the loader.
// Handshake: a byte moves on a rising clk edge when rx_valid & rx_ready are both 1.
// The sender holds rx_data stable while rx_valid is high. rx_ready does not depend on rx_valid.
interface rom_loader_if
  import rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic                  ram_we;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, ram_addr, ram_din, ram_we
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/rom_loader_timeout.sv
// Idle-gap counter for the loader. It flags expiry on the clock that would complete
// TIMEOUT_CYCLES consecutive enabled clocks since the last clear.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/rom_loader.sv
// Packs a header-framed byte stream into 12-bit words and writes them to program RAM
// from address 0, holding the CPU in reset until the whole program has been written.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  rom_loader_if.master        bus,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_error,
  output logic [ADDR_WIDTH:0] words_loaded,
  output state_e              dbg_state_o
);
  localparam int CNT_W = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      words_q, words_d;
  logic [CNT_W-1:0]      words_inc;
  logic [3:0]            nibble_q, nibble_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  start_pend_q, start_pend_d;

  logic rx_ready;
  logic xfer;
  logic to_clr;
  logic to_en;
  logic to_expired;

  assign rx_ready  = (state_q == HEADER) || (state_q == HI) || (state_q == LO);
  assign xfer      = bus.rx_valid && rx_ready;
  assign words_inc = words_q + CNT_W'(1);

  // The gap timer runs only while a frame is in flight, and restarts on each byte
  // and whenever a new word begins.
  assign to_en  = ((state_q == HI) || (state_q == LO)) && !xfer;
  assign to_clr = xfer || ((state_d == HI) && (state_q != HI));

  loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (to_clr),
    .en_i      (to_en),
    .expired_o (to_expired)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    words_d      = words_q;
    nibble_d     = nibble_q;
    addr_d       = addr_q;
    din_d        = din_q;
    start_pend_d = start_pend_q;

    if (state_q == WRITE) begin
      // A write always completes; a start seen now takes effect one cycle later.
      if (start) begin
        start_pend_d = 1'b1;
      end
      words_d = words_inc;
      if (words_inc == count_q) begin
        state_d = DONE;
      end else begin
        addr_d  = addr_q + ADDR_WIDTH'(1);
        state_d = HI;
      end
    end else if (start || start_pend_q) begin
      state_d      = HEADER;
      words_d      = '0;
      start_pend_d = 1'b0;
    end else begin
      case (state_q)
        HEADER: begin
          if (xfer) begin
            count_d = (bus.rx_data == 8'h00) ? CNT_W'(1 << ADDR_WIDTH) : CNT_W'(bus.rx_data);
            addr_d  = '0;
            state_d = HI;
          end
        end
        HI: begin
          if (xfer) begin
            if ((bus.rx_data & HI_RSVD_MASK) != 8'h00) begin
              state_d = ERROR;
            end else begin
              nibble_d = bus.rx_data[3:0];
              state_d  = LO;
            end
          end else if (to_expired) begin
            state_d = ERROR;
          end
        end
        LO: begin
          if (xfer) begin
            din_d   = DATA_WIDTH'({nibble_q, bus.rx_data});
            state_d = WRITE;
          end else if (to_expired) begin
            state_d = ERROR;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= HEADER;
      count_q      <= '0;
      words_q      <= '0;
      nibble_q     <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      start_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      words_q      <= words_d;
      nibble_q     <= nibble_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      start_pend_q <= start_pend_d;
    end
  end

  // Status flags decode straight from the state register so reset clears them at once.
  assign bus.rx_ready  = rx_ready;
  assign bus.ram_we    = (state_q == WRITE);
  assign bus.ram_addr  = addr_q;
  assign bus.ram_din   = din_q;
  assign cpu_hold      = (state_q != DONE);
  assign load_done     = (state_q == DONE);
  assign load_error    = (state_q == ERROR);
  assign words_loaded  = words_q;
  assign dbg_state_o   = state_q;
endmodule
